// File: rtl/jpeg_bit_packer.sv
// Packs right-justified variable-length entropy codes MSB-first into 32-bit words.
// A flush pads the final partial word with PAD_BIT and reports completion.
module jpeg_bit_packer #(
  parameter int CODE_W  = 27,
  parameter bit PAD_BIT = 1'b1
) (
  input  logic              clk,
  input  logic              img_rst_n,
  input  logic [CODE_W-1:0] code_in,
  input  logic [4:0]        code_len,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic              flush_in,
  output logic [31:0]       jpeg_out,
  output logic              jpeg_valid,
  output logic              flush_done,
  output logic              len_err
);

  localparam int ACC_W  = 31;
  localparam int COMB_W = ACC_W + CODE_W;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        out_q, out_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               len_ok;
  logic [COMB_W-1:0]  code_mask;
  logic [COMB_W-1:0]  comb;
  logic [5:0]         c_total;
  logic [5:0]         rem;
  logic [31:0]        word;
  logic [COMB_W-1:0]  rem_mask;
  logic [5:0]         fill_sh;
  logic [31:0]        pad_word;

  // Pending bits are kept right-justified in acc_q with all higher bits zero.
  always_comb begin
    len_ok    = (code_len <= 5'(CODE_W));
    code_mask = (COMB_W'(1) << code_len) - COMB_W'(1);
    comb      = (COMB_W'(acc_q) << code_len) | (COMB_W'(code_in) & code_mask);
    c_total   = {1'b0, cnt_q} + {1'b0, code_len};
    rem       = c_total - 6'd32;
    word      = 32'(comb >> rem);
    rem_mask  = (COMB_W'(1) << rem) - COMB_W'(1);
    fill_sh   = 6'd32 - {1'b0, cnt_q};
    pad_word  = (32'({1'b0, acc_q}) << fill_sh)
              | (PAD_BIT ? ~(32'hFFFF_FFFF << fill_sh) : 32'h0);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      RUN: begin
        if (code_valid) begin
          if (!len_ok) begin
            err_d = 1'b1;
          end else if (c_total >= 6'd32) begin
            out_d   = word;
            valid_d = 1'b1;
            acc_d   = ACC_W'(comb & rem_mask);
            cnt_d   = rem[4:0];
          end else begin
            acc_d = ACC_W'(comb);
            cnt_d = c_total[4:0];
          end
        end
        if (flush_in) state_d = FLUSH;
      end
      FLUSH: begin
        if (cnt_q != 5'd0) begin
          out_d   = pad_word;
          valid_d = 1'b1;
        end
        acc_d   = '0;
        cnt_d   = 5'd0;
        done_d  = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge img_rst_n) begin
    if (!img_rst_n) begin
      state_q <= RUN;
      acc_q   <= '0;
      cnt_q   <= 5'd0;
      out_q   <= 32'h0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign code_ready = (state_q == RUN);
  assign jpeg_out   = out_q;
  assign jpeg_valid = valid_q;
  assign flush_done = done_q;
  assign len_err    = err_q;

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Directed bench for jpeg_bit_packer: a bit-queue model pushes expected words
// into a scoreboard as stimulus is driven; each cycle's output pops and compares.
module tb_jpeg_bit_packer;

  logic        clk;
  logic        img_rst_n;
  logic [26:0] code_in;
  logic [4:0]  code_len;
  logic        code_valid;
  logic        code_ready;
  logic        flush_in;
  logic [31:0] jpeg_out;
  logic        jpeg_valid;
  logic        flush_done;
  logic        len_err;

  int checks   = 0;
  int failures = 0;

  bit          mq[$];
  logic [31:0] exq[$];
  logic        m_flush = 1'b0;
  logic        m_err   = 1'b0;
  logic [31:0] exp_out = 32'h0;

  jpeg_bit_packer #(.CODE_W(27), .PAD_BIT(1'b1)) dut (
    .clk        (clk),
    .img_rst_n  (img_rst_n),
    .code_in    (code_in),
    .code_len   (code_len),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .flush_in   (flush_in),
    .jpeg_out   (jpeg_out),
    .jpeg_valid (jpeg_valid),
    .flush_done (flush_done),
    .len_err    (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: model the cycle, clock the DUT, compare after the edge.
  task automatic step(input logic v, input logic [26:0] code, input logic [4:0] len,
                      input logic fl);
    logic [31:0] w;
    logic        nxt_flush;
    logic        exp_fd;
    logic        exp_v;
    int          n;
    exp_fd = 1'b0;
    if (!m_flush) begin
      if (v) begin
        if (len > 5'd27) begin
          m_err = 1'b1;
        end else begin
          for (int i = int'(len) - 1; i >= 0; i--) mq.push_back(code[i]);
          if (mq.size() >= 32) begin
            w = 32'h0;
            for (int i = 0; i < 32; i++) w = {w[30:0], mq.pop_front()};
            exq.push_back(w);
          end
        end
      end
      nxt_flush = fl;
    end else begin
      n = mq.size();
      if (n > 0) begin
        w = 32'h0;
        for (int i = 0; i < 32; i++) w = {w[30:0], (i < n) ? mq.pop_front() : 1'b1};
        exq.push_back(w);
      end
      mq.delete();
      exp_fd    = 1'b1;
      nxt_flush = 1'b0;
    end
    code_valid = v;
    code_in    = code;
    code_len   = len;
    flush_in   = fl;
    @(posedge clk);
    #1;
    m_flush = nxt_flush;
    exp_v   = (exq.size() > 0);
    if (exp_v) exp_out = exq.pop_front();
    chk("jpeg_valid", 32'(jpeg_valid), 32'(exp_v));
    chk("jpeg_out",   jpeg_out, exp_out);
    chk("flush_done", 32'(flush_done), 32'(exp_fd));
    chk("code_ready", 32'(code_ready), 32'(!m_flush));
    chk("len_err",    32'(len_err), 32'(m_err));
  endtask

  initial begin
    img_rst_n  = 1'b0;
    code_in    = '0;
    code_len   = '0;
    code_valid = 1'b0;
    flush_in   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out",   jpeg_out, 32'h0);
    chk("rst_valid", 32'(jpeg_valid), 32'h0);
    chk("rst_done",  32'(flush_done), 32'h0);
    chk("rst_err",   32'(len_err), 32'h0);
    chk("rst_ready", 32'(code_ready), 32'h1);
    img_rst_n = 1'b1;

    // Idle after reset release
    repeat (10) step(1'b0, 27'h0, 5'd0, 1'b0);

    // Eight 4-bit all-ones symbols fill exactly one word
    repeat (8) step(1'b1, 27'hF, 5'd4, 1'b0);
    step(1'b0, 27'h0, 5'd0, 1'b0);

    // Eleven 3'b101 symbols with dirty upper bits, then flush the 1 pending bit
    repeat (11) step(1'b1, 27'h7FF_FFFD, 5'd3, 1'b0);
    step(1'b0, 27'h0, 5'd0, 1'b1);
    step(1'b0, 27'h0, 5'd0, 1'b0);
    step(1'b0, 27'h0, 5'd0, 1'b0);

    // Five zero bits flushed, then a back-to-back empty flush
    step(1'b1, 27'h0, 5'd5, 1'b0);
    step(1'b0, 27'h0, 5'd0, 1'b1);
    step(1'b0, 27'h0, 5'd0, 1'b0);
    step(1'b0, 27'h0, 5'd0, 1'b1);
    step(1'b0, 27'h0, 5'd0, 1'b0);

    // Zero-length symbol is a no-op
    step(1'b1, 27'h7FF_FFFF, 5'd0, 1'b0);

    // Two maximal symbols, flush on the second: two consecutive words
    step(1'b1, 27'h7FF_FFFF, 5'd27, 1'b0);
    step(1'b1, 27'h7FF_FFFF, 5'd27, 1'b1);
    step(1'b0, 27'h0, 5'd0, 1'b0);
    step(1'b0, 27'h0, 5'd0, 1'b0);

    // Illegal lengths are dropped and latch len_err; symbols in FLUSH are ignored
    step(1'b1, 27'h7FF_FFFF, 5'd28, 1'b0);
    step(1'b1, 27'h5, 5'd3, 1'b0);
    step(1'b1, 27'h7FF_FFFF, 5'd31, 1'b0);
    step(1'b1, 27'h2A, 5'd6, 1'b0);
    step(1'b0, 27'h0, 5'd0, 1'b1);
    step(1'b1, 27'h7FF_FFFF, 5'd4, 1'b1);
    step(1'b0, 27'h0, 5'd0, 1'b0);

    // Reset pulse while in FLUSH with pending bits
    step(1'b1, 27'h0, 5'd2, 1'b0);
    step(1'b0, 27'h0, 5'd0, 1'b1);
    #2;
    img_rst_n = 1'b0;
    #1;
    chk("arst_out",   jpeg_out, 32'h0);
    chk("arst_valid", 32'(jpeg_valid), 32'h0);
    chk("arst_done",  32'(flush_done), 32'h0);
    chk("arst_err",   32'(len_err), 32'h0);
    chk("arst_ready", 32'(code_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("arst_hold_valid", 32'(jpeg_valid), 32'h0);
    chk("arst_hold_done",  32'(flush_done), 32'h0);
    img_rst_n = 1'b1;
    mq.delete();
    exq.delete();
    m_flush = 1'b0;
    m_err   = 1'b0;
    exp_out = 32'h0;
    step(1'b0, 27'h0, 5'd0, 1'b0);
    step(1'b0, 27'h0, 5'd0, 1'b0);

    // Accumulator is empty after reset: one zero bit pads to 0x7FFFFFFF
    step(1'b1, 27'h0, 5'd1, 1'b1);
    step(1'b0, 27'h0, 5'd0, 1'b0);
    step(1'b0, 27'h0, 5'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
